// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice: default address and
// data widths, and the port-index encoding used by the round-robin arbiter
// (port 0 is the CPU M-stage data port, port 1 is the loader/DMA port).
package dmem_arbiter_pkg;

    localparam int unsigned AW_DEF = 12;
    localparam int unsigned DW_DEF = 32;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_e;

    // The port that did not win; round-robin hands priority to it.
    function automatic port_e other_port(input port_e p);
        return (p == PORT_CPU) ? PORT_DMA : PORT_CPU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. Grants are combinational in the request
// cycle; the single priority bit remembers which port wins the next tie.
//
// Ports:
//   clk   - clock, priority updates on the rising edge
//   rst   - asynchronous active-high reset; forces priority to port 0 and
//           suppresses all grants while high
//   req0  - port 0 request
//   req1  - port 1 request
//   gnt0  - port 0 granted this cycle
//   gnt1  - port 1 granted this cycle
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    port_e prio;
    port_e granted;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (req0 && req1) begin
                gnt0 = (prio == PORT_CPU);
                gnt1 = (prio == PORT_DMA);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign granted = gnt1 ? PORT_DMA : PORT_CPU;

    // Priority moves only when something was granted, so idle cycles and
    // requests withdrawn before winning leave it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= PORT_CPU;
        end else if (gnt0 || gnt1) begin
            prio <= other_port(granted);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-ported data RAM between the CPU data port (port 0) and
// the loader/DMA port (port 1). One access per cycle, round-robin on ties.
// Reads: RAM data is combinational, captured at the end of the grant cycle
// and presented with a one-cycle rvalid pulse on the following cycle.
//
// Ports:
//   CLK, RST            - clock; asynchronous active-high reset
//   req0/we0/addr0/wdata0 - port 0 request, write enable, address, data
//   gnt0, stall0        - port 0 accepted this cycle; CPU stall (req0 & ~gnt0)
//   rdata0, rvalid0     - port 0 registered read data and its valid pulse
//   req1/we1/addr1/wdata1, gnt1, rdata1, rvalid1 - same for port 1
//   ram_addr/ram_wdata/ram_we/ram_cs - RAM command, zero when nothing granted
//   ram_rdata           - RAM read data, valid in the same cycle as ram_addr
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic [DW-1:0] rdata0,
    output logic          rvalid0,
    output logic          stall0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic [DW-1:0] rdata1,
    output logic          rvalid1,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_we,
    output logic          ram_cs,
    input  logic [DW-1:0] ram_rdata
);

    logic rd_gnt0;
    logic rd_gnt1;

    rr_arb2 u_arb (
        .clk  (CLK),
        .rst  (RST),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign stall0  = req0 & ~gnt0;
    assign rd_gnt0 = gnt0 & ~we0;
    assign rd_gnt1 = gnt1 & ~we1;

    // RAM command mux. Write data is forced to zero unless this is a write,
    // so the bus never carries stale port data on reads or idle cycles.
    always_comb begin
        ram_cs    = gnt0 | gnt1;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_addr = addr0;
            ram_we   = we0;
            if (we0) begin
                ram_wdata = wdata0;
            end
        end else if (gnt1) begin
            ram_addr = addr1;
            ram_we   = we1;
            if (we1) begin
                ram_wdata = wdata1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid0 <= 1'b0;
            rdata0  <= '0;
        end else begin
            rvalid0 <= rd_gnt0;
            if (rd_gnt0) begin
                rdata0 <= ram_rdata;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rvalid1 <= 1'b0;
            rdata1  <= '0;
        end else begin
            rvalid1 <= rd_gnt1;
            if (rd_gnt1) begin
                rdata1 <= ram_rdata;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001 Parameter: AW, 12, RAM byte-address width.
- REQ-002 Parameter: DW, 32, data width.
- REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
- REQ-004 RST  input  1  asynchronous, active-high reset.
- REQ-005 req0  input  1  port 0 (CPU data, M stage) access request; level, held until granted.
- REQ-006 we0  input  1  port 0 write enable (1 = write, 0 = read).
- REQ-007 addr0  input  AW  port 0 address.
- REQ-008 wdata0  input  DW  port 0 write data.
- REQ-009 gnt0  output  1  port 0 access accepted this cycle.
- REQ-010 rdata0  output  DW  port 0 registered read data.
- REQ-011 rvalid0  output  1  rdata0 valid, one-cycle pulse.
- REQ-012 stall0  output  1  CPU pipeline stall, equal to req0 & ~gnt0.
- REQ-013 req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: port 1 (loader/DMA), same widths and meanings as port 0.
- REQ-014 ram_addr  output  AW  RAM address.
- REQ-015 ram_wdata  output  DW  RAM write data, driven only when ram_we = 1.
- REQ-016 ram_we  output  1  RAM write strobe (R_W).
- REQ-017 ram_cs  output  1  RAM chip select, high only during a granted cycle.
- REQ-018 ram_rdata  input  DW  RAM read data, combinational, valid in the same cycle as ram_addr.

Function
- REQ-019 Arbitration is combinational per cycle: at most one of gnt0/gnt1 is high; a grant requires the matching req.
- REQ-020 Only one requesting port: that port is granted.
- REQ-021 Both ports requesting: the port selected by 1-bit register prio is granted (prio = 0 selects port 0).
- REQ-022 prio updates only on a grant cycle: it is set to the port that was not granted (round-robin). It holds in idle cycles.
- REQ-023 Starvation bound: a continuously requesting port is granted within 2 cycles.
- REQ-024 On a grant cycle, ram_addr, ram_we, ram_wdata and ram_cs are driven from the granted port. With no grant, ram_cs = 0, ram_we = 0, ram_addr = 0 and ram_wdata = 0.
- REQ-025 Read latency: when a read is granted in cycle N, ram_rdata is captured into rdataX at the edge ending cycle N. rvalidX is high for exactly cycle N+1.
- REQ-026 A granted write produces no rvalid pulse. The write commits at the edge ending the grant cycle.
- REQ-027 rdataX holds its last value when rvalidX = 0.
- REQ-028 Back-to-back: one access per cycle with no bubble. Consecutive grants to the same or alternating ports are legal.
- REQ-029 Write then read of the same address on consecutive cycles: the read returns the newly written data.
- REQ-030 A request dropped before it is granted is discarded silently; no state changes.

Reset
- REQ-031 Asserting RST, at any time including mid-access, forces prio = 0, rvalid0 = rvalid1 = 0 and rdata0 = rdata1 = 0 immediately.
- REQ-032 While RST is high, gnt0 = gnt1 = 0, ram_cs = 0, ram_we = 0 and stall0 = req0. No RAM write occurs.
- REQ-033 After RST is released, the first grant follows REQ-020/REQ-021 with prio = 0.

Structure
- REQ-034 The shared package holds AW/DW defaults and a port-index constant (PORT_CPU = 0, PORT_DMA = 1).
- REQ-035 One sub-module, rr_arb2, holds the 2-way round-robin grant logic and the prio register. The datapath muxes and read registers sit in dmem_arbiter.

Verification
- REQ-036 Single read: req0 = 1, we0 = 0, addr0 = 0x010, RAM word = 0xDEADBEEF -> gnt0 in cycle 0, rvalid0 = 1 and rdata0 = 0xDEADBEEF in cycle 1, stall0 = 0.
- REQ-037 Contention: req0 and req1 both held high 4 cycles after reset -> grant sequence 0,1,0,1; stall0 = 1 in cycles 1 and 3.
- REQ-038 Write-read: port 1 writes 0x12345678 to 0x020, then port 0 reads 0x020 the next cycle -> rdata0 = 0x12345678 with rvalid0.
- REQ-039 Reset mid-read: RST asserted in the cycle after a port 0 read grant -> rvalid0 = 0 at once, no rvalid pulse after release, next contended grant goes to port 0.
- REQ-040 Idle: no requests for 3 cycles -> ram_cs = 0 and ram_we = 0 throughout, prio unchanged, RAM contents unchanged.
